// File: rtl/pwm_duty_ctrl_if.sv
// Button-to-duty control bus: raw buttons in, duty value and debounced levels out.
// Latency: none, this is wiring only.
// Backpressure: none, the duty value is a level that the PWM stage samples every cycle.
interface pwm_duty_ctrl_if;
    logic       btn_up;
    logic       btn_dn;
    logic [7:0] duty;
    logic       duty_valid;
    logic       up_stable;
    logic       dn_stable;

    // Drives the buttons and observes the duty value (board side or bench).
    modport master (
        output btn_up,
        output btn_dn,
        input  duty,
        input  duty_valid,
        input  up_stable,
        input  dn_stable
    );

    // The control block itself.
    modport slave (
        input  btn_up,
        input  btn_dn,
        output duty,
        output duty_valid,
        output up_stable,
        output dn_stable
    );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// Purpose: turns two raw active-low up/down push-buttons into a saturating 8-bit PWM duty value.
// Latency: a held raw edge reaches duty/duty_valid DEBOUNCE_CYCLES+3 clock edges after it is first sampled.
// Backpressure: none; duty is a level and duty_valid pulses for one cycle whenever duty changes.
// Build option: define AUTOREPEAT_EN to add hold-to-repeat (REPEAT_DELAY, then a step every REPEAT_PERIOD).
module pwm_duty_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_PERIOD   = 600000,
    parameter int unsigned STEP            = 1,
    parameter logic [7:0]  DUTY_INIT       = 8'h00
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_duty_ctrl_if.slave bus
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [8:0]      STEP9   = 9'(STEP);

    // A zero-length timing parameter or a step outside 1..255 would make the
    // arithmetic or the timers meaningless; such an instance holds its duty value.
    localparam bit CFG_OK = (STEP >= 1) && (STEP <= 255) && (DEBOUNCE_CYCLES >= 1) &&
                            (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

`ifdef AUTOREPEAT_EN
    localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LOCK = 2'd2
    } state_t;
`endif

    // Index 0 is the up button, index 1 the down button; all levels active low.
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stable;
    logic [DB_W-1:0] db_cnt [2];

    logic            up_pressed;
    logic            dn_pressed;
    logic            held_pressed;

    state_t          state;
    state_t          state_nxt;
    logic            held_up;
    logic            held_up_nxt;
    logic            step_req;
    logic            step_up;

    logic [7:0]      duty;
    logic [7:0]      duty_nxt;
    logic            duty_valid;
    logic [8:0]      sum;
    logic [8:0]      diff;

`ifdef AUTOREPEAT_EN
    logic [31:0]     rep_cnt;
    logic [31:0]     rep_cnt_nxt;
`endif

    assign raw = {bus.btn_dn, bus.btn_up};

    // Two-flop synchroniser per button; reset parks both at the released level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign up_pressed   = ~stable[0];
    assign dn_pressed   = ~stable[1];
    assign held_pressed = held_up ? up_pressed : dn_pressed;

    // FSM state, held direction and repeat timer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            held_up <= 1'b1;
`ifdef AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            held_up <= held_up_nxt;
`ifdef AUTOREPEAT_EN
            rep_cnt <= rep_cnt_nxt;
`endif
        end
    end

    // Next-state and step request. IDLE is only ever entered with the pressed
    // button(s) released, so a pressed level seen in IDLE is the 1->0 press
    // event itself; two pressed levels there means a simultaneous press.
    always_comb begin
        state_nxt   = state;
        held_up_nxt = held_up;
        step_req    = 1'b0;
        step_up     = held_up;
`ifdef AUTOREPEAT_EN
        rep_cnt_nxt = rep_cnt;
`endif
        case (state)
            IDLE: begin
                if (up_pressed && dn_pressed) begin
                    state_nxt = LOCK;
                end else if (up_pressed || dn_pressed) begin
`ifdef AUTOREPEAT_EN
                    state_nxt   = DELAY;
                    rep_cnt_nxt = '0;
`else
                    state_nxt   = HELD;
`endif
                    held_up_nxt = up_pressed;
                    step_req    = 1'b1;
                    step_up     = up_pressed;
                end
            end
`ifdef AUTOREPEAT_EN
            DELAY: begin
                if (up_pressed && dn_pressed) begin
                    state_nxt = LOCK;
                end else if (!held_pressed) begin
                    state_nxt = IDLE;
                end else if (rep_cnt == DELAY_LAST) begin
                    state_nxt   = REPEAT;
                    rep_cnt_nxt = '0;
                    step_req    = 1'b1;
                end else begin
                    rep_cnt_nxt = rep_cnt + 32'd1;
                end
            end
            REPEAT: begin
                // Saturation is handled by the arithmetic; the state keeps repeating.
                if (up_pressed && dn_pressed) begin
                    state_nxt = LOCK;
                end else if (!held_pressed) begin
                    state_nxt = IDLE;
                end else if (rep_cnt == PERIOD_LAST) begin
                    rep_cnt_nxt = '0;
                    step_req    = 1'b1;
                end else begin
                    rep_cnt_nxt = rep_cnt + 32'd1;
                end
            end
`else
            HELD: begin
                if (up_pressed && dn_pressed) begin
                    state_nxt = LOCK;
                end else if (!held_pressed) begin
                    state_nxt = IDLE;
                end
            end
`endif
            LOCK: begin
                // Leave only once both buttons are released, so a half-released
                // pair can never produce a step.
                if (!up_pressed && !dn_pressed) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Saturating step: the 9th bit flags overflow on up and borrow on down.
    always_comb begin
        sum      = {1'b0, duty} + STEP9;
        diff     = {1'b0, duty} - STEP9;
        duty_nxt = duty;
        if (step_req && CFG_OK) begin
            if (step_up) begin
                duty_nxt = sum[8] ? 8'hFF : sum[7:0];
            end else begin
                duty_nxt = diff[8] ? 8'h00 : diff[7:0];
            end
        end
    end

    // Duty register; the valid pulse marks a real change, so steps at a limit are silent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty       <= DUTY_INIT;
            duty_valid <= 1'b0;
        end else begin
            duty       <= duty_nxt;
            duty_valid <= (duty_nxt != duty);
        end
    end

    assign bus.duty       = duty;
    assign bus.duty_valid = duty_valid;
    assign bus.up_stable  = stable[0];
    assign bus.dn_stable  = stable[1];

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl: vector table, hand-written corner sequences and random presses.
// A second instance starting at 255 shares the button stimulus to exercise the upper limit.
module tb_pwm_duty_ctrl;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int ST = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pwm_duty_ctrl_if bus ();
    pwm_duty_ctrl_if bus_hi ();

    assign bus_hi.btn_up = bus.btn_up;
    assign bus_hi.btn_dn = bus.btn_dn;

    pwm_duty_ctrl #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .STEP(ST), .DUTY_INIT(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    pwm_duty_ctrl #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .STEP(ST), .DUTY_INIT(8'hFF)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n), .bus(bus_hi)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Debounce as a sliding window: a button's accepted level flips once the
    // synchronised samples seen on the last D edges all disagree with it.
    // The synchronised sample seen on edge n is the raw level sampled on edge n-2.
    int m_duty, m_hi, m_mode;
    bit m_valid, m_hi_valid, m_st_up, m_st_dn, m_dir;
    bit hq_up[$];
    bit hq_dn[$];
`ifdef AUTOREPEAT_EN
    int m_since;
`endif

    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic bit win_flip(input bit q[$], input bit st);
        for (int i = 0; i < D; i++) begin
            if (q[i] == st) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_duty = 0; m_hi = 255; m_valid = 0; m_hi_valid = 0;
        m_st_up = 1; m_st_dn = 1; m_mode = 0; m_dir = 1;
        hq_up.delete(); hq_dn.delete();
        for (int i = 0; i < D + 1; i++) begin
            hq_up.push_back(1'b1);
            hq_dn.push_back(1'b1);
        end
    endtask

    task automatic model_step(input bit up, input bit dn);
        bit upp, dnp, held;
        int dir, nd;
        upp = !m_st_up; dnp = !m_st_dn; dir = 0;
        held = m_dir ? upp : dnp;
        // mode 0 = idle, 1 = a single button held, 2 = locked by both
        case (m_mode)
            0: begin
                if (upp && dnp) m_mode = 2;
                else if (upp || dnp) begin
                    m_mode = 1; m_dir = upp; dir = upp ? 1 : -1;
`ifdef AUTOREPEAT_EN
                    m_since = 0;
`endif
                end
            end
            1: begin
                if (upp && dnp) m_mode = 2;
                else if (!held) m_mode = 0;
`ifdef AUTOREPEAT_EN
                else begin
                    m_since++;
                    if (m_since == RD || (m_since > RD && (m_since - RD) % RP == 0))
                        dir = m_dir ? 1 : -1;
                end
`endif
            end
            default: if (!upp && !dnp) m_mode = 0;
        endcase
        nd = sat(m_duty + dir * ST);
        m_valid = (nd != m_duty); m_duty = nd;
        nd = sat(m_hi + dir * ST);
        m_hi_valid = (nd != m_hi); m_hi = nd;
        hq_up.push_back(up);
        hq_dn.push_back(dn);
        if (win_flip(hq_up, m_st_up)) m_st_up = !m_st_up;
        if (win_flip(hq_dn, m_st_dn)) m_st_dn = !m_st_dn;
        void'(hq_up.pop_front());
        void'(hq_dn.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step(bus.btn_up, bus.btn_dn);
        end
    end

    // Continuous comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("model_duty", 32'(bus.duty), 32'(m_duty));
            check("model_valid", 32'(bus.duty_valid), 32'(m_valid));
            check("model_up_stable", 32'(bus.up_stable), 32'(m_st_up));
            check("model_dn_stable", 32'(bus.dn_stable), 32'(m_st_dn));
            check("model_hi_duty", 32'(bus_hi.duty), 32'(m_hi));
            check("model_hi_valid", 32'(bus_hi.duty_valid), 32'(m_hi_valid));
            check("model_hi_up_stable", 32'(bus_hi.up_stable), 32'(m_st_up));
            check("model_hi_dn_stable", 32'(bus_hi.dn_stable), 32'(m_st_dn));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed and random stimulus ----------------
    typedef struct {
        int up_len;
        int dn_len;
        int exp_duty;
        int exp_pulses;
        int exp_hi;
    } vec_t;

    vec_t tbl [11];

    task automatic idle(input int n);
        bus.btn_up = 1'b1; bus.btn_dn = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pulses, len;
        bit found;

        tbl[0]  = '{3,  0,  0, 0, 255};   // glitch shorter than the debounce window
        tbl[1]  = '{15, 0,  1, 1, 255};   // up press; upper instance already saturated
        tbl[2]  = '{15, 0,  2, 1, 255};
        tbl[3]  = '{0,  15, 1, 1, 254};
        tbl[4]  = '{0,  15, 0, 1, 253};
        tbl[5]  = '{0,  15, 0, 0, 252};   // down at zero: silent
        tbl[6]  = '{15, 15, 0, 0, 252};   // simultaneous press locks
        tbl[7]  = '{15, 0,  1, 1, 253};
        tbl[8]  = '{4,  0,  2, 1, 254};   // exactly the debounce length is accepted
        tbl[9]  = '{15, 40, 2, 0, 254};   // up released first while locked: no step
        tbl[10] = '{15, 0,  3, 1, 255};   // lock cleared, next press steps again

        bus.btn_up = 1'b1; bus.btn_dn = 1'b1; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_duty", 32'(bus.duty), 32'd0);
        check("reset_valid", 32'(bus.duty_valid), 32'd0);
        check("reset_up_stable", 32'(bus.up_stable), 32'd1);
        check("reset_dn_stable", 32'(bus.dn_stable), 32'd1);
        check("reset_hi_duty", 32'(bus_hi.duty), 32'd255);
        rst_n = 1'b1;
        idle(5);

        for (int v = 0; v < 11; v++) begin
            pulses = 0;
            len = (tbl[v].up_len > tbl[v].dn_len) ? tbl[v].up_len : tbl[v].dn_len;
            for (int c = 0; c < len; c++) begin
                bus.btn_up = (c < tbl[v].up_len) ? 1'b0 : 1'b1;
                bus.btn_dn = (c < tbl[v].dn_len) ? 1'b0 : 1'b1;
                @(negedge clk);
                pulses += int'(bus.duty_valid);
            end
            bus.btn_up = 1'b1; bus.btn_dn = 1'b1;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                pulses += int'(bus.duty_valid);
            end
            check($sformatf("vec%0d_duty", v), 32'(bus.duty), 32'(tbl[v].exp_duty));
            check($sformatf("vec%0d_pulses", v), 32'(pulses), 32'(tbl[v].exp_pulses));
            check($sformatf("vec%0d_hi_duty", v), 32'(bus_hi.duty), 32'(tbl[v].exp_hi));
        end

        // Exact press latency: duty moves on the 7th edge after the first low sample.
        bus.btn_up = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            @(negedge clk);
            if (e == 5) check("lat_up_stable_e5", 32'(bus.up_stable), 32'd1);
            if (e == 6) begin
                check("lat_up_stable_e6", 32'(bus.up_stable), 32'd0);
                check("lat_duty_e6", 32'(bus.duty), 32'd3);
            end
            if (e == 7) begin
                check("lat_duty_e7", 32'(bus.duty), 32'd4);
                check("lat_valid_e7", 32'(bus.duty_valid), 32'd1);
            end
            if (e == 8) check("lat_valid_e8", 32'(bus.duty_valid), 32'd0);
        end
        idle(30);

        // Long hold: auto-repeat steps at T, T+20, T+25 ... T+50 when enabled.
        bus.btn_up = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.duty != 8'd4) found = 1'b1;
        end
        check("hold_press_seen", 32'(found), 32'd1);
        check("hold_duty_t", 32'(bus.duty), 32'd5);
        repeat (50) @(negedge clk);
`ifdef AUTOREPEAT_EN
        check("hold_duty_t50", 32'(bus.duty), 32'd12);
`else
        check("hold_duty_t50", 32'(bus.duty), 32'd5);
`endif
        idle(40);

        // Reset in the middle of a hold: duty returns to init, button is re-debounced.
        bus.btn_up = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_duty", 32'(bus.duty), 32'd0);
        check("midrst_valid", 32'(bus.duty_valid), 32'd0);
        check("midrst_up_stable", 32'(bus.up_stable), 32'd1);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            if (e == 6) check("midrst_duty_e6", 32'(bus.duty), 32'd0);
            if (e == 7) check("midrst_duty_e7", 32'(bus.duty), 32'd1);
        end
        idle(40);

        // Random presses, holds and occasional resets, checked by the model.
        for (int it = 0; it < 300; it++) begin
            int r;
            r = int'($urandom_range(0, 3));
            bus.btn_up = !(r == 0 || r == 2);
            bus.btn_dn = !(r == 1 || r == 2);
            repeat ($urandom_range(1, 40)) @(negedge clk);
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
